// File: rtl/instr_mem_loader.sv
// Framed byte-stream loader for the instruction RAM: length byte, big-endian words, XOR checksum.
// Holds the CPU for the whole session and writes one word per completed group of bytes.
module instr_mem_loader #(
  parameter int n      = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [n-1:0]      mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        words_loaded
);

  localparam int BPW   = n / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready depends on state only, never on byte_valid.
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        wl_q, wl_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic [n-1:0]      word_q, word_d;
  logic [n-1:0]      wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              accept;
  logic [n+7:0]      shifted;

  assign byte_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign busy         = byte_ready;
  assign cpu_hold     = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = wl_q;

  assign accept  = byte_valid && byte_ready;
  // First byte of a word ends up in the top byte once BPW bytes have been shifted in.
  assign shifted = {word_q, byte_in};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    xor_d   = xor_q;
    wl_d    = wl_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          xor_d   = 8'd0;
          wl_d    = 8'd0;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d  = byte_in;
          xor_d  = byte_in;
          bcnt_d = '0;
          if (byte_in > 8'(DEPTH))  state_d = S_ERR;
          else if (byte_in == 8'd0) state_d = S_CSUM;
          else                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ byte_in;
          word_d = shifted[n-1:0];
          if (bcnt_q == CNT_W'(BPW - 1)) begin
            bcnt_d  = '0;
            we_d    = 1'b1;
            wdata_d = shifted[n-1:0];
            addr_d  = wl_q[ADDR_W-1:0];
            wl_d    = wl_q + 8'd1;
            if (wl_q + 8'd1 == len_q) state_d = S_CSUM;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = (byte_in == xor_q) ? S_DONE : S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= 8'd0;
      xor_q   <= 8'd0;
      wl_q    <= 8'd0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      xor_q   <= xor_d;
      wl_q    <= wl_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed frames from the test plan plus random frames
// checked against a frame-level reference model and a write scoreboard.
module tb_instr_mem_loader;

  localparam int N_W    = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int BPW    = N_W / 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [N_W-1:0]    mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        words_loaded;

  instr_mem_loader #(.n(N_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  logic [ADDR_W+N_W-1:0] exp_q[$];
  logic [7:0]            frame_q[$];
  int                    n_send;
  bit                    exp_done;
  bit                    exp_err;
  int                    exp_wl;
  int                    exp_len;

  always @(negedge clk) begin
    if (!rst && mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+N_W-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, e[ADDR_W+N_W-1:N_W], e[N_W-1:0]);
        end
      end
    end
  end

  // Reference: interpret the frame from its rules and predict writes and outcome.
  task automatic model_frame();
    logic [7:0] x;
    logic [N_W-1:0] w;
    exp_len  = frame_q[0];
    exp_done = 0;
    exp_err  = 0;
    if (exp_len > DEPTH) begin
      n_send  = 1;
      exp_err = 1;
      exp_wl  = 0;
      return;
    end
    n_send = 2 + exp_len * BPW;
    x = 8'd0;
    for (int i = 0; i < n_send - 1; i++) x = x ^ frame_q[i];
    for (int k = 0; k < exp_len; k++) begin
      w = '0;
      for (int b = 0; b < BPW; b++) w = (w << 8) | N_W'(frame_q[1 + k*BPW + b]);
      exp_q.push_back({ADDR_W'(k), w});
    end
    exp_wl   = exp_len;
    exp_done = (frame_q[n_send-1] == x);
    exp_err  = !exp_done;
  endtask

  task automatic build_random_frame(input int nw, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    frame_q.delete();
    frame_q.push_back(8'(nw));
    x = 8'(nw);
    if (nw <= DEPTH) begin
      for (int i = 0; i < nw * BPW; i++) begin
        b = 8'($urandom_range(0, 255));
        frame_q.push_back(b);
        x = x ^ b;
      end
      if (corrupt) x = x ^ 8'($urandom_range(1, 255));
      frame_q.push_back(x);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    bit acc;
    bit rdy;
    byte_valid = 1'b1;
    byte_in    = b;
    acc = 0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    byte_valid = 1'b0;
    byte_in    = 8'($urandom_range(0, 255));
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL accept_timeout: byte %h not accepted within 20 cycles, required acceptance", b);
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if ({byte_ready, busy, cpu_hold, err, done, words_loaded} !== {4'b1110, 1'b0, 8'd0}) begin
      n_bad++;
      $display("FAIL start_state: got rdy/busy/hold/err/done=%b%b%b%b%b wl=%0d, required 11100 wl=0",
               byte_ready, busy, cpu_hold, err, done, words_loaded);
    end
  endtask

  task automatic run_frame(input int gap_max, input bit mid_start);
    bit we_exp;
    model_frame();
    start_session();
    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      if (mid_start && i == 3) start = 1'b1;
      send_byte(frame_q[i]);
      start = 1'b0;
      we_exp = (i >= 1) && (i <= exp_len * BPW) && (i % BPW == 0);
      n_cmp++;
      if (mem_we !== we_exp || (we_exp && mem_addr !== ADDR_W'(i / BPW - 1))) begin
        n_bad++;
        $display("FAIL write_timing: byte %0d got we=%b addr=%0d, required we=%b addr=%0d",
                 i, mem_we, mem_addr, we_exp, i / BPW - 1);
      end
    end
    n_cmp++;
    if ({done, err, cpu_hold, busy, byte_ready} !== {exp_done, exp_err, 3'b100} ||
        words_loaded !== 8'(exp_wl)) begin
      n_bad++;
      $display("FAIL outcome: got done/err/hold/busy/rdy=%b%b%b%b%b wl=%0d, required %b%b100 wl=%0d",
               done, err, cpu_hold, busy, byte_ready, words_loaded, exp_done, exp_err, exp_wl);
    end
    @(posedge clk);
    #1;
    if (exp_done) begin
      n_cmp++;
      if ({done, err, cpu_hold, busy} !== 4'b0000 || words_loaded !== 8'(exp_wl)) begin
        n_bad++;
        $display("FAIL after_done: got done/err/hold/busy=%b%b%b%b wl=%0d, required 0000 wl=%0d",
                 done, err, cpu_hold, busy, words_loaded, exp_wl);
      end
    end else begin
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({done, err, cpu_hold, busy} !== 4'b0110 || words_loaded !== 8'(exp_wl)) begin
        n_bad++;
        $display("FAIL err_sticky: got done/err/hold/busy=%b%b%b%b wl=%0d, required 0110 wl=%0d",
                 done, err, cpu_hold, busy, words_loaded, exp_wl);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_two_word(input logic [7:0] csum);
    frame_q = '{8'h02, 8'h80, 8'h20, 8'h00, 8'h0A, 8'h04, 8'h40, 8'h08, 8'h00, csum};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata, words_loaded} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got rdy=%b we=%b hold=%b busy=%b done=%b err=%b, required all 0",
               byte_ready, mem_we, cpu_hold, busy, done, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({byte_ready, mem_we, cpu_hold, busy, done, err, words_loaded} !== '0) begin
        n_bad++;
        $display("FAIL reset_idle: cycle %0d got rdy=%b we=%b hold=%b busy=%b done=%b err=%b, required all 0",
                 c, byte_ready, mem_we, cpu_hold, busy, done, err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_word();
    load_two_word(8'hE4);
    run_frame(0, 0);
  endtask

  task automatic test_gaps_mid_start();
    load_two_word(8'hE4);
    run_frame(3, 1);
  endtask

  task automatic test_bad_csum();
    load_two_word(8'hE5);
    run_frame(0, 0);
    load_two_word(8'hE4);
    run_frame(1, 0);
  endtask

  task automatic test_length_bounds();
    frame_q = '{8'h41};
    run_frame(0, 0);
    frame_q = '{8'h00, 8'h00};
    run_frame(0, 0);
    build_random_frame(DEPTH, 0);
    run_frame(0, 0);
  endtask

  task automatic test_reset_mid_frame();
    load_two_word(8'hE4);
    model_frame();
    void'(exp_q.pop_back());
    start_session();
    for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, err, mem_addr, mem_wdata, words_loaded} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got rdy=%b we=%b hold=%b busy=%b wl=%0d, required all 0",
               byte_ready, mem_we, cpu_hold, busy, words_loaded);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || cpu_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_writes: got %0d pending hold=%b, required 0 pending hold=0",
               exp_q.size(), cpu_hold);
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    int nw;
    for (int f = 0; f < 12; f++) begin
      nw = ($urandom_range(0, 5) == 0) ? $urandom_range(DEPTH + 1, 255) : $urandom_range(0, 6);
      build_random_frame(nw, $urandom_range(0, 3) == 0);
      run_frame($urandom_range(0, 2), $urandom_range(0, 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    test_reset();
    test_two_word();
    test_gaps_mid_start();
    test_bad_csum();
    test_length_bounds();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream program loader that writes the instruction memory, the write-side counterpart of the processor's PC-indexed instruction fetch. It accepts a framed byte stream (length, big-endian instruction bytes, XOR checksum) on a valid/ready interface. It assembles 32-bit words and issues one write per word to the instruction RAM at consecutive word addresses from 0. While a load is in progress it holds the processor stalled via `cpu_hold`.

## Interface
- `n`, 32: instruction word width; multiple of 8. Bytes per word `BPW = n/8`.
- `DEPTH`, 64: instruction memory depth in words; 1..255.
- `ADDR_W`, 6: word-address width; `2**ADDR_W >= DEPTH`.

Ports. Clock `clk`, single clock domain; reset `rst`, asynchronous, active-high.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  begin a load session; sampled only in IDLE or ERR.
- `byte_in`  in  8  stream data byte.
- `byte_valid`  in  1  `byte_in` valid.
- `byte_ready`  out  1  loader accepts the byte this cycle.
- `mem_we`  out  1  instruction RAM write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  n  instruction word to write.
- `cpu_hold`  out  1  processor stall/hold request.
- `busy`  out  1  session in progress (LEN, DATA, CSUM).
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error flag.
- `words_loaded`  out  8  words written in the current or last session.

## Operation
- A byte is accepted on a rising edge where `byte_valid && byte_ready`.
- Frame format: byte 0 = word count N, then N×BPW data bytes, then one checksum byte. The checksum equals the XOR of the length byte and all data bytes.
- Data byte order is big-endian: the first byte of a word goes to bits [n-1:n-8].
- States:
  - IDLE: `start` → LEN.
  - LEN: accept the length byte. If N > DEPTH → ERR, with no writes. If N = 0 → CSUM. Otherwise → DATA, with address 0.
  - DATA: shift bytes into the word register. On the BPW-th byte, register a write and increment the address and `words_loaded`. After word N-1 → CSUM.
  - CSUM: accept one byte. If it matches the running XOR → DONE. Otherwise → ERR.
  - DONE: `done`=1 for one cycle → IDLE.
  - ERR: `err`=1, `cpu_hold` stays 1. `start` clears `err` and `words_loaded` and goes to LEN. All other input is ignored.
- `byte_ready` = 1 in LEN, DATA and CSUM; 0 elsewhere.
- `start` is ignored in LEN, DATA, CSUM and DONE.
- Words already written before an ERR are not rolled back.
- `cpu_hold` = 1 in every state except IDLE.
- `busy` = 1 in LEN, DATA and CSUM.
- Running XOR: cleared on entry to LEN; 8-bit.
- `words_loaded`: cleared on entry to LEN; never exceeds DEPTH.

## Timing
- Reset state: IDLE. Reset values of all outputs: `byte_ready`, `mem_we`, `cpu_hold`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `words_loaded` = 0.
- Reset mid-session abandons the frame. A partially assembled word is never written.
- `start` is sampled at edge t → state LEN and `byte_ready`=1 from cycle t+1.
- Write latency: the last byte of word k is accepted at edge t. In the cycle after t, `mem_we`=1 with `mem_addr`=k and `mem_wdata` = the full word. `mem_we` returns to 0 the following cycle unless another word completes.
- Back-to-back bytes are accepted every cycle with no bubbles. `byte_valid` gaps only stretch the session.
- The checksum byte is accepted at edge t → `done`=1 in the cycle after t. `cpu_hold` and `busy` drop one cycle later (DONE → IDLE).
- A bad checksum or N > DEPTH accepted at edge t → `err`=1 in the cycle after t.
- Minimum session: 2 + N×BPW accepted bytes, plus one DONE cycle.

## Test plan
- Reset: assert `rst` with no clock → all outputs 0. Release and idle 5 cycles → outputs stay 0 and no `mem_we`.
- Two-word load, `start` then bytes 02, 80,20,00,0A, 04,40,08,00, E4 every cycle → writes addr0=0x8020000A and addr1=0x04400800, each one cycle after its 4th byte. `done` pulses one cycle after E4. `words_loaded`=2, `err`=0, `cpu_hold` falls one cycle after `done`.
- Same frame with random `byte_valid` gaps, plus `start` pulsed mid-frame → identical writes and `done`; the mid-frame `start` has no effect.
- Bad checksum (last byte E5) → both words written, `err`=1 sticky, no `done`, `cpu_hold` stays 1. A new `start` clears `err`.
- Length 0x41 with DEPTH=64 → `err`=1 the cycle after the length byte, zero writes. Length 00 then checksum 00 → `done`, `words_loaded`=0.
- `rst` asserted after 2 bytes of word 1 of the two-word frame → outputs 0 immediately, and no write to addr1.
